full_adder: RTL and testbench
=============================

Name: full_adder

Overview:
- Registered binary adder: sum/cout = A + B + cin, captured on the rising clock edge.
- Default WIDTH=1 gives the classic single-bit full adder; wider instances form a ripple-carry adder built from 1-bit cells.
- Leaf arithmetic primitive for datapath blocks and for gate-level flow testing (synthesis, netlist simulation, timing).

Parameters:
- WIDTH, 1, operand and sum width in bits; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- A  input  WIDTH  operand A, unsigned.
- B  input  WIDTH  operand B, unsigned.
- cin  input  1  carry-in, weight 2^0.
- sum  output  WIDTH  registered low WIDTH bits of A+B+cin.
- cout  output  1  registered carry-out, weight 2^WIDTH.

Behaviour:
- Combinational core: {c_out, s} = A + B + cin, computed at WIDTH+1 bits. No truncation before the carry is formed.
- Per-bit cell equations:
  - s_i = a_i ^ b_i ^ c_i
  - c_(i+1) = (a_i & b_i) | (a_i & c_i) | (b_i & c_i)
  - c_0 = cin; cout = c_WIDTH.
- Output register: on each rising clk edge with rst=0, sum<=s and cout<=c_out.
- Latency is exactly 1 cycle: inputs stable before edge N appear on sum/cout after edge N. New inputs are accepted every cycle; there is no stall or handshake.
- Reset: on a rising clk edge with rst=1, sum<=0 and cout<=0, regardless of inputs.
  - rst takes priority over the data update when both occur on the same edge.
  - rst has no asynchronous effect; outputs hold until the next edge.
  - Reset asserted mid-stream discards the in-flight result. The first valid result after deassertion reflects the inputs at the first edge with rst=0.
- Before the first clock edge, outputs are undefined (X in simulation). The bench must apply reset or ignore outputs until the first edge.
- Wrap-around: the all-ones case A=B=2^WIDTH-1 with cin=1 gives sum=2^WIDTH-1, cout=1. No overflow flag; signed interpretation is the user's concern.
- X/Z on inputs propagates to outputs. No sanitising.
- No latches. Every output is driven from a flop.

Decomposition:
- No shared package needed; the only constant is WIDTH.
- Sub-module full_adder_cell: purely combinational 1-bit cell with a, b, ci in and s, co out, implementing the equations above.
- full_adder instantiates WIDTH cells in a generate loop with the carry chain, then adds the output register stage.

Test Plan:
- Reset: rst=1 for 2 cycles with A=1, B=1, cin=1 -> sum=0, cout=0 on both edges; rst=0 -> next edge sum=1, cout=1.
- Exhaustive WIDTH=1: all 8 combinations of (A,B,cin), one per cycle -> after 1 cycle, (0,0,0)->s0 c0, (0,0,1)->s1 c0, (0,1,1)->s0 c1, (1,1,0)->s0 c1, (1,1,1)->s1 c1; the remaining rows follow the same equations.
- Latency/throughput: change inputs every cycle; each result must appear exactly one edge later with no bubbles or duplicates.
- WIDTH=8 boundaries:
  - A=8'hFF, B=8'h00, cin=1 -> sum=8'h00, cout=1.
  - A=8'hFF, B=8'hFF, cin=1 -> sum=8'hFF, cout=1.
  - A=8'h7F, B=8'h01, cin=0 -> sum=8'h80, cout=0.
- Mid-stream reset: assert rst for one edge between two non-zero operand sets -> that edge outputs 0/0; the following edge outputs the new operand result.
- Random WIDTH=16: 10,000 random A, B, cin per cycle -> {cout,sum} matches the reference model A+B+cin delayed by one cycle.

Source files
------------

// File: rtl/full_adder_pkg.sv
// Bit-level helpers shared by the adder cells.
// Each helper states one full-adder equation in the form it is usually written on paper.
package full_adder_pkg;

    // Sum bit of a full adder: odd parity of the three inputs.
    function automatic logic fa_sum(input logic a, input logic b, input logic c);
        return a ^ b ^ c;
    endfunction

    // Carry bit of a full adder: majority of the three inputs.
    function automatic logic fa_carry(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Purely combinational 1-bit full-adder cell.
// These cells are chained by the top level to form a ripple-carry adder.
module full_adder_cell
    import full_adder_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = fa_sum(a, b, ci);
    assign co = fa_carry(a, b, ci);

endmodule

// File: rtl/full_adder.sv
// Registered ripple-carry adder: {cout, sum} = A + B + cin, one cycle of latency.
// WIDTH is legal from 1 to 64. WIDTH=1 is the classic single-bit full adder.
// There is no stall and no handshake. A new operand set is accepted on every clock edge.
module full_adder #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] sum_q;
    logic             cout_d;
    logic             cout_q;

    // Each stage keeps its own carry nets, so the chain is a straight line of
    // separate signals rather than one self-referencing vector.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic c_in;
        logic c_out;

        if (i == 0) begin : g_first
            assign c_in = cin;
        end else begin : g_rest
            assign c_in = g_bit[i-1].c_out;
        end

        full_adder_cell u_cell (
            .a  (A[i]),
            .b  (B[i]),
            .ci (c_in),
            .s  (sum_d[i]),
            .co (c_out)
        );
    end

    assign cout_d = g_bit[WIDTH-1].c_out;

    // Output stage. Reset wins over the data update and clears any in-flight result.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_full_adder.sv
// Bench for full_adder: exercises 1-, 8- and 16-bit instances side by side.
// The reference model is plain integer addition A+B+cin, kept to WIDTH+1 bits.
module tb_full_adder;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // ---------------- DUT signals ----------------
    logic        a1, b1, c1;
    logic        s1, co1;
    logic [7:0]  a8, b8, s8;
    logic        c8, co8;
    logic [15:0] a16, b16, s16;
    logic        c16, co16;

    full_adder #(.WIDTH(1)) u_dut_w1 (
        .clk(clk), .rst(rst), .A(a1), .B(b1), .cin(c1), .sum(s1), .cout(co1)
    );

    full_adder #(.WIDTH(8)) u_dut_w8 (
        .clk(clk), .rst(rst), .A(a8), .B(b8), .cin(c8), .sum(s8), .cout(co8)
    );

    full_adder #(.WIDTH(16)) u_dut_w16 (
        .clk(clk), .rst(rst), .A(a16), .B(b16), .cin(c16), .sum(s16), .cout(co16)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;

    logic [16:0] exp1_q[$];
    logic [16:0] exp8_q[$];
    logic [16:0] exp16_q[$];

    // Reference: the arithmetic sum kept to w+1 bits. A reset edge forces zero.
    function automatic logic [16:0] ref_add(input int w, input longint unsigned a,
                                            input longint unsigned b, input bit c,
                                            input bit r);
        longint unsigned total;
        longint unsigned mask;
        if (r) return '0;
        total = a + b + longint'(c);
        mask  = (64'd1 << (w + 1)) - 64'd1;
        return 17'(total & mask);
    endfunction

    task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: {cout,sum} got %h, expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Records the expected result of the inputs present now, lets one edge pass,
    // then compares all three instances just after that edge.
    task automatic tick(input string tag);
        exp1_q.push_back(ref_add(1, longint'(a1), longint'(b1), c1, rst));
        exp8_q.push_back(ref_add(8, longint'(a8), longint'(b8), c8, rst));
        exp16_q.push_back(ref_add(16, longint'(a16), longint'(b16), c16, rst));
        @(posedge clk);
        #1;
        check({tag, "/w1"},  {15'd0, co1, s1},  exp1_q.pop_front());
        check({tag, "/w8"},  {8'd0, co8, s8},   exp8_q.pop_front());
        check({tag, "/w16"}, {co16, s16},       exp16_q.pop_front());
    endtask

    task automatic set_all(input logic [15:0] a, input logic [15:0] b, input logic c);
        a1 = a[0];  b1 = b[0];  c1 = c;
        a8 = a[7:0]; b8 = b[7:0]; c8 = c;
        a16 = a;    b16 = b;    c16 = c;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [2:0] combo;

        // Reset held for two edges with non-zero operands, then released.
        rst = 1'b1;
        set_all(16'd1, 16'd1, 1'b1);
        tick("reset_edge0");
        tick("reset_edge1");
        rst = 1'b0;
        tick("reset_release");

        // All eight 1-bit input combinations, one per cycle.
        for (int i = 0; i < 8; i++) begin
            combo = 3'(i);
            set_all(16'h00A5 ^ 16'(i), 16'h0F3C + 16'(i), combo[0]);
            a1 = combo[2];
            b1 = combo[1];
            c1 = combo[0];
            tick($sformatf("exh_%0d", i));
        end

        // 8-bit boundary cases (16-bit instance sees the same zero-extended operands).
        set_all(16'h00FF, 16'h0000, 1'b1); tick("bnd_ff_00_c1");
        set_all(16'h00FF, 16'h00FF, 1'b1); tick("bnd_ff_ff_c1");
        set_all(16'h007F, 16'h0001, 1'b0); tick("bnd_7f_01_c0");
        set_all(16'hFFFF, 16'hFFFF, 1'b1); tick("bnd_all_ones");

        // Mid-stream reset between two non-zero operand sets.
        set_all(16'h1234, 16'h4321, 1'b1); tick("mid_pre");
        rst = 1'b1;
        set_all(16'h5555, 16'h6666, 1'b1); tick("mid_rst");
        rst = 1'b0;
        set_all(16'hA0A0, 16'h0F0F, 1'b0); tick("mid_post");

        // Random back-to-back traffic: new operands every cycle.
        for (int i = 0; i < 10000; i++) begin
            a1  = 1'($urandom_range(0, 1));
            b1  = 1'($urandom_range(0, 1));
            c1  = 1'($urandom_range(0, 1));
            a8  = 8'($urandom_range(0, 255));
            b8  = 8'($urandom_range(0, 255));
            c8  = 1'($urandom_range(0, 1));
            a16 = 16'($urandom_range(0, 65535));
            b16 = 16'($urandom_range(0, 65535));
            c16 = 1'($urandom_range(0, 1));
            tick("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
